// File: rtl/branch_predict_ctrl.sv
// Branch predictor and mispredict redirect controller: a table of 2-bit saturating
// counters feeds decode, and execute-stage resolution updates the table and the perf counters.
module branch_predict_ctrl #(
  parameter int DataWidth   = 32,
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 d_valid,
  input  logic                 d_is_branch,
  input  logic [DataWidth-1:0] d_pc,
  input  logic [DataWidth-1:0] d_target,
  output logic                 d_pred_taken,
  output logic [DataWidth-1:0] d_pred_pc,
  input  logic                 e_valid,
  input  logic                 e_is_branch,
  input  logic [DataWidth-1:0] e_pc,
  input  logic [DataWidth-1:0] e_target,
  input  logic                 e_pred_taken,
  input  logic                 e_branch,
  output logic                 redirect,
  output logic [DataWidth-1:0] redirect_pc,
  output logic                 flush_fd,
  output logic                 flush_de,
  output logic [DataWidth-1:0] branch_cnt,
  output logic [DataWidth-1:0] mispred_cnt
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REDIRECT = 1'b1} state_e;

  state_e               state_r, state_nxt_s;
  logic [1:0]           bht_r [BHT_ENTRIES];
  logic [IDX_W-1:0]     d_idx_s, e_idx_s;
  logic                 res_s, mispred_s, d_pred_taken_s;
  logic [1:0]           bht_cur_s, bht_upd_s;
  logic [DataWidth-1:0] redirect_pc_r, branch_cnt_r, mispred_cnt_r;
  logic                 unused_pc_bits_s;

  // Word-aligned PCs: bits [1:0] never reach the index.
  assign d_idx_s          = d_pc[IDX_W+1:2];
  assign e_idx_s          = e_pc[IDX_W+1:2];
  assign unused_pc_bits_s = ^{d_pc[DataWidth-1:IDX_W+2], d_pc[1:0]};

  // Decode prediction; suppressed while the front end is being redirected.
  always_comb begin
    d_pred_taken_s = 1'b0;
    if (d_valid && d_is_branch && (state_r == ST_IDLE)) begin
      d_pred_taken_s = bht_r[d_idx_s][1];
    end else begin
      d_pred_taken_s = 1'b0;
    end
  end

  // Resolution qualification and saturating counter next value.
  always_comb begin
    res_s     = e_valid & e_is_branch & ~stall & (state_r == ST_IDLE);
    mispred_s = res_s & (e_branch ^ e_pred_taken);
    bht_cur_s = bht_r[e_idx_s];
    bht_upd_s = bht_cur_s;
    if (e_branch) begin
      if (bht_cur_s != 2'b11) begin
        bht_upd_s = bht_cur_s + 2'b01;
      end else begin
        bht_upd_s = bht_cur_s;
      end
    end else begin
      if (bht_cur_s != 2'b00) begin
        bht_upd_s = bht_cur_s - 2'b01;
      end else begin
        bht_upd_s = bht_cur_s;
      end
    end
  end

  // Next-state logic: REDIRECT always lasts a single cycle regardless of stall.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mispred_s) begin
          state_nxt_s = ST_REDIRECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REDIRECT: state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counter table; reset returns every entry to weakly not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (res_s) begin
      bht_r[e_idx_s] <= bht_upd_s;
    end
  end

  // Performance counters and the captured redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_r  <= {DataWidth{1'b0}};
      mispred_cnt_r <= {DataWidth{1'b0}};
      redirect_pc_r <= {DataWidth{1'b0}};
    end else begin
      if (res_s) begin
        branch_cnt_r <= branch_cnt_r + DataWidth'(1);
      end
      if (mispred_s) begin
        mispred_cnt_r <= mispred_cnt_r + DataWidth'(1);
        redirect_pc_r <= e_branch ? e_target : (e_pc + DataWidth'(4));
      end
    end
  end

  assign d_pred_taken = d_pred_taken_s;
  assign d_pred_pc    = d_target;
  assign redirect     = (state_r == ST_REDIRECT);
  assign flush_fd     = (state_r == ST_REDIRECT);
  assign flush_de     = (state_r == ST_REDIRECT);
  assign redirect_pc  = redirect_pc_r;
  assign branch_cnt   = branch_cnt_r;
  assign mispred_cnt  = mispred_cnt_r;

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch prediction and redirect controller for the Buraq-mini RV32IM pipeline.
- Holds a table of 2-bit saturating counters indexed by PC. Supplies a taken/not-taken prediction to decode.
- Resolves each branch in execute against the Branch signal from the branch comparator. On a mispredict it sequences a one-cycle redirect-and-flush of the front end.
- Keeps branch and mispredict performance counters.

Parameters:
- DataWidth, 32, width of PC, target and counters.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 4.
- IDX_W, $clog2(BHT_ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; blocks resolution when high.
- d_valid  in  1  decode-stage instruction valid.
- d_is_branch  in  1  decode instruction is a conditional branch.
- d_pc  in  DataWidth  decode PC.
- d_target  in  DataWidth  decode branch target (pc+imm).
- d_pred_taken  out  1  prediction for the decode branch.
- d_pred_pc  out  DataWidth  next fetch PC when d_pred_taken=1; equals d_target.
- e_valid  in  1  execute-stage instruction valid.
- e_is_branch  in  1  execute instruction is a conditional branch.
- e_pc  in  DataWidth  execute PC.
- e_target  in  DataWidth  execute branch target.
- e_pred_taken  in  1  prediction carried down the pipe with this branch.
- e_branch  in  1  actual outcome from the branch comparator.
- redirect  out  1  fetch must load redirect_pc this cycle.
- redirect_pc  out  DataWidth  corrected fetch PC.
- flush_fd  out  1  kill IF/ID register contents.
- flush_de  out  1  kill ID/EX register contents.
- branch_cnt  out  DataWidth  resolved branches.
- mispred_cnt  out  DataWidth  resolved mispredicts.

Behaviour:
- Reset:
  - All counters set to 2'b01 (weakly not-taken); FSM goes to IDLE.
  - redirect, flush_fd, flush_de = 0; redirect_pc, branch_cnt, mispred_cnt = 0.
  - A reset in the REDIRECT state aborts the redirect; outputs are 0 in the next cycle.
- Index: pc[IDX_W+1:2]; PC bits [1:0] are ignored.
- Prediction (combinational):
  - d_pred_taken = d_valid & d_is_branch & bht[idx(d_pc)][1] & (state==IDLE).
  - d_pred_pc = d_target, unconditionally.
- Resolution event: res = e_valid & e_is_branch & ~stall & (state==IDLE).
- On res, at the clock edge:
  - bht[idx(e_pc)] saturating update: +1 if e_branch (cap at 3), -1 if not (floor at 0).
  - branch_cnt += 1.
  - If e_branch != e_pred_taken: mispred_cnt += 1 and FSM goes IDLE->REDIRECT.
  - Counters wrap modulo 2^DataWidth.
- Same-cycle read and update of the same index: decode sees the old value; no bypass.
- FSM states:
  - IDLE: redirect = flush_fd = flush_de = 0.
  - IDLE->REDIRECT: taken on a mispredict. redirect_pc is registered as e_branch ? e_target : e_pc+4 (mod 2^DataWidth).
  - REDIRECT: lasts exactly 1 cycle, with redirect = flush_fd = flush_de = 1. The stall input does not extend it.
    - Execute inputs are ignored (the execute instruction is wrong-path).
    - d_pred_taken is forced to 0.
    - No counter or BHT updates.
  - REDIRECT->IDLE: unconditional.
- Latency: a mispredict resolved in cycle N gives redirect=1 in cycle N+1. Resolution resumes in cycle N+2.
- Correct predictions never produce redirect.
- stall=1 in IDLE: no BHT update, no counting, no state change. Prediction output remains live.
- Non-branch or invalid execute instructions cause no update.

Test Plan:
- Reset, then decode a branch at pc 0x100 -> d_pred_taken=0; all outputs and counters 0.
- Resolve pc 0x100 taken with pred=0, target 0x200 -> next cycle redirect=1, flush_fd=flush_de=1, redirect_pc=0x200; mispred_cnt=1, branch_cnt=1; the cycle after that redirect=0.
- Resolve pc 0x40 taken 4 times, each with e_pred_taken matching the current prediction -> counter 01→10→11→11 (saturates). A decode at 0x40 then predicts 1. Two not-taken resolutions bring it to 01 -> predicts 0.
- Mispredict not-taken (pred=1, e_branch=0, e_pc=0xFFFFFFFC) -> redirect_pc=0x00000000 (wrap).
- Apply a valid branch with a mismatch in the REDIRECT cycle -> ignored: counts unchanged, no second redirect.
- stall=1 with a valid mismatching branch -> no update. Release stall -> the redirect follows one cycle later.
- Assert reset during REDIRECT -> redirect=0 next cycle, counters 0, BHT back to 01.
- Use pcs 0x000 and 0x100 with BHT_ENTRIES=64 (the same index) -> an update via one pc changes the prediction for the other.
